// File: rtl/fft_fixed_pkg.sv
// Shared sign-magnitude field helpers and the stage-1 register layout
// for the fixed-point add/sub pipeline.
package fft_fixed_pkg;
  localparam int MAX_W  = 32;
  localparam int STAGES = 2;

  function automatic int SIGN_BIT(input int w);
    return w - 1;
  endfunction

  function automatic int MAG_W(input int w);
    return w - 1;
  endfunction

  // Magnitudes are stored at the widest legal size; upper bits stay zero.
  typedef struct packed {
    logic             sa;
    logic             sb;
    logic             a_ge;
    logic [MAX_W-2:0] mag_l;
    logic [MAX_W-2:0] mag_s;
  } s1_t;
endpackage

// File: rtl/fixed_point_addsub_pipe_if.sv
// Operand/result handshake bundle for the fixed-point add/sub pipeline.
interface fixed_point_addsub_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             ovf;
  logic             ovf_sticky;
  logic             clr_ovf;

  modport master (
    output in_valid, a, b, sub, out_ready, clr_ovf,
    input  in_ready, out_valid, c, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready, clr_ovf,
    output in_ready, out_valid, c, ovf, ovf_sticky
  );
endinterface

// File: rtl/sm_addsub_core.sv
// Combinational sign-magnitude add/subtract on pre-ordered operands.
module sm_addsub_core
  import fft_fixed_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1
) (
  input  s1_t              s1,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);
  localparam int MW = MAG_W(WIDTH);

  logic [MAX_W-1:0] sum, diff;
  logic [MW-1:0]    mag;
  logic             sgn;
  logic             unused_hi;

  assign sum       = {1'b0, s1.mag_l} + {1'b0, s1.mag_s};
  assign diff      = {1'b0, s1.mag_l} - {1'b0, s1.mag_s};
  assign unused_hi = ^{sum, diff};

  always_comb begin
    ovf = 1'b0;
    mag = '0;
    sgn = 1'b0;
    if (s1.sa == s1.sb) begin
      sgn = s1.sa;
      ovf = sum[MW];
      mag = (ovf && SATURATE) ? '1 : sum[MW-1:0];
    end else begin
      // mag_l >= mag_s by construction, so the difference never borrows
      sgn = s1.a_ge ? s1.sa : s1.sb;
      mag = diff[MW-1:0];
    end
  end

  // Zero magnitude is always emitted as +0
  assign c = {(|mag) & sgn, mag};
endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready flow control
// and a sticky overflow flag.
module fixed_point_addsub_pipe
  import fft_fixed_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1
) (
  input logic                       clk,
  input logic                       n_rst,
  fixed_point_addsub_pipe_if.slave  bus
);
  localparam int MW = MAG_W(WIDTH);
  localparam int SB = SIGN_BIT(WIDTH);

  logic [STAGES:1]  vld_pipe;
  logic             en;
  logic             sa, sb, a_ge;
  logic [MW-1:0]    ma, mb;
  s1_t              s1_d, s1_q;
  logic [WIDTH-1:0] core_c, c_q;
  logic             core_ovf, ovf_q, sticky_q;

  assign en   = !vld_pipe[2] || bus.out_ready;
  assign sa   = bus.a[SB];
  assign sb   = bus.b[SB] ^ bus.sub;
  assign ma   = bus.a[MW-1:0];
  assign mb   = bus.b[MW-1:0];
  assign a_ge = ma >= mb;

  always_comb begin
    s1_d                = '0;
    s1_d.sa             = sa;
    s1_d.sb             = sb;
    s1_d.a_ge           = a_ge;
    s1_d.mag_l[MW-1:0]  = a_ge ? ma : mb;
    s1_d.mag_s[MW-1:0]  = a_ge ? mb : ma;
  end

  sm_addsub_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
    .s1  (s1_q),
    .c   (core_c),
    .ovf (core_ovf)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[1], bus.in_valid};
      s1_q     <= s1_d;
      // Bubbles land as zero so c/ovf never show stale data
      c_q      <= vld_pipe[1] ? core_c : '0;
      ovf_q    <= vld_pipe[1] & core_ovf;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                               sticky_q <= 1'b0;
    else if (vld_pipe[2] && bus.out_ready && ovf_q) sticky_q <= 1'b1;
    else if (bus.clr_ovf)                     sticky_q <= 1'b0;
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = vld_pipe[2];
  assign bus.c          = c_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Scoreboard bench: a saturating and a wrapping instance run in lockstep
// on the same directed operand stream.
module tb_fixed_point_addsub_pipe;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] cs, cw;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] cs, cw;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  fixed_point_addsub_pipe_if #(.WIDTH(W)) bus0 ();
  fixed_point_addsub_pipe_if #(.WIDTH(W)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.sub       = bus0.sub;
  assign bus1.out_ready = bus0.out_ready;
  assign bus1.clr_ovf   = bus0.clr_ovf;

  fixed_point_addsub_pipe #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .clk(clk), .n_rst(n_rst), .bus(bus0));
  fixed_point_addsub_pipe #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk(clk), .n_rst(n_rst), .bus(bus1));

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t vecs[16];
  bit   rmode = 1'b0;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              input logic [W-1:0] cs, input logic [W-1:0] cw, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.sub = s; v.cs = cs; v.cw = cw; v.ovf = o;
    return v;
  endfunction

  // Output-ready driver: held high, or cycling 1,0,0,1
  initial begin
    int pidx = 0;
    bus0.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus0.out_ready = rmode ? pat[pidx] : 1'b1;
      pidx = (pidx + 1) % 4;
    end
  end

  // Monitor: pops expected results on each output transfer, checks stalls
  initial begin
    logic [W-1:0] hold_c;
    bit           hold_v;
    exp_t         e;
    hold_v = 1'b0;
    hold_c = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_valid_held", bus0.out_valid, 1);
          chk("stall_c_held", bus0.c, hold_c);
        end
        hold_v = 1'b0;
        if (bus0.out_valid) begin
          chk("lockstep_valid", bus1.out_valid, 1);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual c=%0h required=no output", bus0.c);
          end else if (bus0.out_ready) begin
            e = q.pop_front();
            chk("c_sat", bus0.c, e.cs);
            chk("ovf_sat", bus0.ovf, e.ovf);
            chk("c_wrap", bus1.c, e.cw);
            chk("ovf_wrap", bus1.ovf, e.ovf);
          end else begin
            hold_v = 1'b1;
            hold_c = bus0.c;
            chk("stall_in_ready_low", bus0.in_ready, 0);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input vec_t v);
    int   n;
    logic rdy;
    exp_t e;
    bus0.in_valid = 1'b1;
    bus0.a = v.a;
    bus0.b = v.b;
    bus0.sub = v.sub;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus0.in_ready;
      @(posedge clk);
      if (rdy) begin
        e.cs = v.cs; e.cw = v.cw; e.ovf = v.ovf;
        q.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=in_ready low required=accept within 50 cycles");
        break;
      end
    end
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    vecs[0]  = mk(16'h0003, 16'h8001, 1'b0, 16'h0002, 16'h0002, 1'b0);
    vecs[1]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b1);
    vecs[2]  = mk(16'h8005, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[3]  = mk(16'h0005, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0);
    vecs[4]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    vecs[5]  = mk(16'h0002, 16'h0007, 1'b1, 16'h8005, 16'h8005, 1'b0);
    vecs[6]  = mk(16'h8003, 16'h8004, 1'b0, 16'h8007, 16'h8007, 1'b0);
    vecs[7]  = mk(16'hFFFF, 16'h8001, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    vecs[8]  = mk(16'h1234, 16'h0111, 1'b0, 16'h1345, 16'h1345, 1'b0);
    vecs[9]  = mk(16'h8100, 16'h8100, 1'b1, 16'h0000, 16'h0000, 1'b0);
    vecs[10] = mk(16'h0010, 16'h8020, 1'b1, 16'h0030, 16'h0030, 1'b0);
    vecs[11] = mk(16'h4000, 16'h4000, 1'b0, 16'h7FFF, 16'h0000, 1'b1);
    vecs[12] = mk(16'h8010, 16'h0003, 1'b0, 16'h800D, 16'h800D, 1'b0);
    vecs[13] = mk(16'h7FFE, 16'h0001, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0);
    vecs[14] = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0);
    vecs[15] = mk(16'h8007, 16'h0002, 1'b1, 16'h8009, 16'h8009, 1'b0);

    n_rst = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.a = '0;
    bus0.b = '0;
    bus0.sub = 1'b0;
    bus0.clr_ovf = 1'b0;
    #3;
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_c", bus0.c, 0);
    chk("rst_sticky", bus0.ovf_sticky, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus0.in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: out_valid two cycles after the accepting cycle
    send(vecs[0]);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", bus0.out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", bus0.out_valid, 1);
    drain("lat_drain");
    @(posedge clk);
    #1;

    // 8-operand stream under a 1,0,0,1 out_ready pattern
    rmode = 1'b1;
    for (int i = 1; i <= 8; i++) send(vecs[i]);
    bus0.in_valid = 1'b0;
    drain("stream_drain");
    rmode = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_sticky", bus0.ovf_sticky, 1);

    // Full-throughput burst
    for (int i = 9; i <= 15; i++) send(vecs[i]);
    bus0.in_valid = 1'b0;
    drain("burst_drain");
    @(posedge clk);
    #1;

    // Async reset with two results in flight
    send(vecs[12]);
    send(vecs[13]);
    bus0.in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("inflight_rst_valid", bus0.out_valid, 0);
    chk("inflight_rst_valid_wrap", bus1.out_valid, 0);
    chk("inflight_rst_c", bus0.c, 0);
    chk("inflight_rst_ovf", bus0.ovf, 0);
    chk("inflight_rst_sticky", bus0.ovf_sticky, 0);
    chk("inflight_rst_in_ready", bus0.in_ready, 1);
    q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_after_rst", bus0.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Clear coinciding with a delivered overflow: set wins
    send(vecs[1]);
    bus0.in_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus0.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("clr_wait_valid", bus0.out_valid, 1);
    end
    chk("sticky_before_set", bus0.ovf_sticky, 0);
    bus0.clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    bus0.clr_ovf = 1'b0;
    chk("sticky_set_wins", bus0.ovf_sticky, 1);
    bus0.clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    bus0.clr_ovf = 1'b0;
    chk("sticky_cleared", bus0.ovf_sticky, 0);
    drain("final_drain");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
